// File: rtl/fixed_param_streamer.sv
// fixed_param_streamer: holds one parameter tensor, loaded once as UNROLL-wide beats,
// and replays it REPEAT times per frame over a valid/ready stream.
module fixed_param_streamer #(
  parameter int DATA_WIDTH = 4,
  parameter int TOTAL_NUM  = 16,
  parameter int UNROLL     = 4,
  parameter int REPEAT     = 73
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [UNROLL-1:0][DATA_WIDTH-1:0]   load_data,
  input  logic                                load_valid,
  output logic                                load_ready,
  input  logic                                start,
  input  logic                                reload,
  output logic [UNROLL-1:0][DATA_WIDTH-1:0]   data_out,
  output logic                                data_out_valid,
  input  logic                                data_out_ready,
  output logic [$clog2(REPEAT+1)-1:0]         pass_count,
  output logic                                done
);

  localparam int DEPTH  = TOTAL_NUM / UNROLL;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PASS_W = $clog2(REPEAT + 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REPEAT - 1);

  typedef logic [UNROLL-1:0][DATA_WIDTH-1:0] beat_t;
  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

  state_t            state;
  beat_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_inc;
  logic [PASS_W-1:0] pass;
  logic              load_fire;
  logic              out_fire;

  // load_ready is only ever high in LOAD, so it also gates out-of-state load_valid
  assign load_fire  = load_valid && load_ready;
  assign out_fire   = data_out_valid && data_out_ready;
  assign rd_inc     = rd_ptr + 1'b1;
  assign pass_count = pass;

  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem[wr_ptr] <= load_data;
    end
  end

  // data_out is registered, so each transition preloads the beat that will be shown next
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= LOAD;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      pass           <= '0;
      load_ready     <= 1'b1;
      data_out_valid <= 1'b0;
      done           <= 1'b0;
      data_out       <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (load_fire) begin
            if (wr_ptr == LAST_PTR) begin
              state          <= STREAM;
              wr_ptr         <= '0;
              rd_ptr         <= '0;
              pass           <= '0;
              load_ready     <= 1'b0;
              data_out_valid <= 1'b1;
              // with a single-beat tensor the beat to show is the one arriving now
              data_out       <= (DEPTH == 1) ? load_data : mem[0];
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
            end
          end
        end
        STREAM: begin
          if (out_fire) begin
            if (rd_ptr == LAST_PTR) begin
              rd_ptr <= '0;
              pass   <= pass + 1'b1;
              if (pass == LAST_PASS) begin
                state          <= DONE;
                data_out_valid <= 1'b0;
                done           <= 1'b1;
                data_out       <= '0;
              end else begin
                data_out <= mem[0];
              end
            end else begin
              rd_ptr   <= rd_inc;
              data_out <= mem[rd_inc];
            end
          end
        end
        DONE: begin
          if (reload) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            pass       <= '0;
            load_ready <= 1'b1;
            done       <= 1'b0;
          end else if (start) begin
            state          <= STREAM;
            rd_ptr         <= '0;
            pass           <= '0;
            data_out_valid <= 1'b1;
            done           <= 1'b0;
            data_out       <= mem[0];
          end
        end
        default: begin
          state          <= LOAD;
          wr_ptr         <= '0;
          rd_ptr         <= '0;
          pass           <= '0;
          load_ready     <= 1'b1;
          data_out_valid <= 1'b0;
          done           <= 1'b0;
          data_out       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_param_streamer.sv
// Directed testbench for fixed_param_streamer: a DEPTH=4/REPEAT=3 instance and a
// DEPTH=1/REPEAT=2 instance, checked with immediate assertions.
module tb_fixed_param_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0][3:0] a_load_data;
  logic            a_load_valid;
  logic            a_load_ready;
  logic            a_start;
  logic            a_reload;
  logic [3:0][3:0] a_data_out;
  logic            a_valid;
  logic            a_ready;
  logic [1:0]      a_pass;
  logic            a_done;

  logic [3:0][3:0] b_load_data;
  logic            b_load_valid;
  logic            b_load_ready;
  logic            b_start;
  logic            b_reload;
  logic [3:0][3:0] b_data_out;
  logic            b_valid;
  logic            b_ready;
  logic [1:0]      b_pass;
  logic            b_done;

  int tests_run    = 0;
  int tests_failed = 0;

  fixed_param_streamer #(.DATA_WIDTH(4), .TOTAL_NUM(16), .UNROLL(4), .REPEAT(3)) dut_a (
    .clk(clk), .rst(rst),
    .load_data(a_load_data), .load_valid(a_load_valid), .load_ready(a_load_ready),
    .start(a_start), .reload(a_reload),
    .data_out(a_data_out), .data_out_valid(a_valid), .data_out_ready(a_ready),
    .pass_count(a_pass), .done(a_done)
  );

  fixed_param_streamer #(.DATA_WIDTH(4), .TOTAL_NUM(4), .UNROLL(4), .REPEAT(2)) dut_b (
    .clk(clk), .rst(rst),
    .load_data(b_load_data), .load_valid(b_load_valid), .load_ready(b_load_ready),
    .start(b_start), .reload(b_reload),
    .data_out(b_data_out), .data_out_valid(b_valid), .data_out_ready(b_ready),
    .pass_count(b_pass), .done(b_done)
  );

  // element i sits in nibble i: beat {1,2,3,4} is 16'h4321
  localparam logic [3:0][15:0] BEATS  = {16'h0FED, 16'hCBA9, 16'h8765, 16'h4321};
  localparam logic [3:0][15:0] SEVENS = {16'h7777, 16'h7777, 16'h7777, 16'h7777};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic lv, input logic [15:0] ld, input logic rdy,
                               input logic st, input logic rl);
    a_load_valid = lv;
    a_load_data  = ld;
    a_ready      = rdy;
    a_start      = st;
    a_reload     = rl;
    @(posedge clk);
    #1;
    a_load_valid = 1'b0;
    a_start      = 1'b0;
    a_reload     = 1'b0;
  endtask

  // streams one full frame (12 beats), checking every cycle; optional mid-stream request pulses
  task automatic streamFrame(input logic [3:0][15:0] exp, input logic [3:0] pat, input logic pulse);
    int   k   = 0;
    int   cyc = 0;
    logic rdy;
    while (k < 12 && cyc < 100) begin
      checkOutput("stream_valid", 32'(a_valid), 32'd1);
      checkOutput("stream_data", 32'(a_data_out), 32'(exp[k % 4]));
      checkOutput("stream_pass", 32'(a_pass), 32'(k / 4));
      rdy = pat[cyc % 4];
      applyStimulus(1'b1, 16'hFFFF, rdy, pulse && (cyc == 5), pulse && (cyc == 9));
      if (rdy) k++;
      cyc++;
    end
    checkOutput("frame_beats", 32'(k), 32'd12);
    checkOutput("frame_done", 32'(a_done), 32'd1);
    checkOutput("frame_valid_low", 32'(a_valid), 32'd0);
    checkOutput("frame_pass", 32'(a_pass), 32'd3);
  endtask

  initial begin
    a_load_data = '0; a_load_valid = 0; a_start = 0; a_reload = 0; a_ready = 0;
    b_load_data = '0; b_load_valid = 0; b_start = 0; b_reload = 0; b_ready = 1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_load_ready", 32'(a_load_ready), 32'd1);
    checkOutput("rst_valid", 32'(a_valid), 32'd0);
    checkOutput("rst_done", 32'(a_done), 32'd0);
    checkOutput("rst_pass", 32'(a_pass), 32'd0);
    checkOutput("rst_data", 32'(a_data_out), 32'd0);
    checkOutput("rst_b_load_ready", 32'(b_load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // load with a gap carrying junk data
    applyStimulus(1'b1, BEATS[0], 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, BEATS[1], 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, BEATS[2], 1'b0, 1'b0, 1'b0);
    checkOutput("valid_before_last_load", 32'(a_valid), 32'd0);
    checkOutput("load_ready_mid_load", 32'(a_load_ready), 32'd1);
    applyStimulus(1'b1, BEATS[3], 1'b0, 1'b0, 1'b0);
    checkOutput("load_ready_after_load", 32'(a_load_ready), 32'd0);
    checkOutput("first_beat_after_load", 32'(a_data_out), 32'(BEATS[0]));

    // backpressure 1-0-0-1 with start/reload pulses mid-stream
    streamFrame(BEATS, 4'b1001, 1'b1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("done_hold", 32'(a_done), 32'd1);
    checkOutput("done_hold_valid", 32'(a_valid), 32'd0);

    // restart
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("restart_done_low", 32'(a_done), 32'd0);
    streamFrame(BEATS, 4'b1111, 1'b0);

    // start and reload together: reload wins
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("reload_load_ready", 32'(a_load_ready), 32'd1);
    checkOutput("reload_valid", 32'(a_valid), 32'd0);
    checkOutput("reload_done", 32'(a_done), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, SEVENS[i], 1'b1, 1'b0, 1'b0);
    streamFrame(SEVENS, 4'b1111, 1'b0);

    // mid-stream reset during pass 1
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_pass", 32'(a_pass), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(a_valid), 32'd0);
    checkOutput("async_rst_load_ready", 32'(a_load_ready), 32'd1);
    checkOutput("async_rst_pass", 32'(a_pass), 32'd0);
    checkOutput("async_rst_data", 32'(a_data_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(a_valid), 32'd0);
    checkOutput("post_rst_load_ready", 32'(a_load_ready), 32'd1);

    // DEPTH=1, REPEAT=2
    b_load_data  = 16'h5A93;
    b_load_valid = 1'b1;
    @(posedge clk);
    #1;
    b_load_valid = 1'b0;
    checkOutput("d1_valid0", 32'(b_valid), 32'd1);
    checkOutput("d1_data0", 32'(b_data_out), 32'h5A93);
    checkOutput("d1_pass0", 32'(b_pass), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("d1_valid1", 32'(b_valid), 32'd1);
    checkOutput("d1_data1", 32'(b_data_out), 32'h5A93);
    checkOutput("d1_pass1", 32'(b_pass), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("d1_valid_end", 32'(b_valid), 32'd0);
    checkOutput("d1_done", 32'(b_done), 32'd1);
    checkOutput("d1_pass_end", 32'(b_pass), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fixed_param_streamer.md
# fixed_param_streamer

Transmit-side counterpart of the weight/bias valid/ready ports consumed by `fixed_patch_embed`, `fixed_block` and the linear/MLP cores. The block stores one parameter tensor, loaded once as a stream of UNROLL-wide beats, and replays it to a consumer in order. The full tensor is replayed REPEAT times per frame, once per token or sliding window. It sits between the parameter loader and each `weight_*`/`bias_*` input of the ViT datapath.

## Interface
- DATA_WIDTH, 4: bits per parameter element (fixed-point, passed through untouched)
- TOTAL_NUM, 16: elements in the tensor; must be a multiple of UNROLL
- UNROLL, 4: elements per beat; DEPTH = TOTAL_NUM/UNROLL beats (DEPTH ≥ 1)
- REPEAT, 73: full-tensor passes per frame (REPEAT ≥ 1)
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- load_data  input  DATA_WIDTH × [UNROLL]  parameter beat to store
- load_valid  input  1  load beat present
- load_ready  output  1  block accepts load beat
- start  input  1  single-cycle request to replay a new frame
- reload  input  1  single-cycle request to accept a new tensor
- data_out  output  DATA_WIDTH × [UNROLL]  replayed parameter beat
- data_out_valid  output  1  beat present
- data_out_ready  input  1  consumer accepts beat
- pass_count  output  $clog2(REPEAT+1)  completed passes in current frame
- done  output  1  frame complete, idle

## Operation
- Storage: DEPTH × UNROLL register array; wr_ptr, rd_ptr in [0, DEPTH-1]; pass counter in [0, REPEAT].
- States:
  - LOAD: load_ready=1. On each load_valid&&load_ready, store the beat at mem[wr_ptr] and increment wr_ptr. The beat taken at wr_ptr==DEPTH-1 moves to STREAM with wr_ptr=0, rd_ptr=0, pass=0.
  - STREAM: data_out = mem[rd_ptr], data_out_valid=1. On each data_out_valid&&data_out_ready, rd_ptr increments. At rd_ptr==DEPTH-1, rd_ptr wraps to 0 and pass increments. The beat completing pass REPEAT moves to DONE.
  - DONE: done=1, data_out_valid=0. start moves to STREAM with rd_ptr=0, pass=0. reload moves to LOAD with wr_ptr=0. If start and reload are asserted together, reload wins.
- Ignored inputs:
  - start and reload are ignored in LOAD and STREAM.
  - load_valid is ignored outside LOAD.
- Ordering: beat k of every pass equals load beat k. Element i of load_data maps to element i of data_out.
- pass_count reports the live pass counter; it holds REPEAT in DONE.
- The first frame starts automatically after the first load; later frames require start.

## Timing
- Reset (rst=0, asynchronous) values:
  - state=LOAD, wr_ptr=rd_ptr=pass=0
  - load_ready=1, data_out_valid=0, done=0, pass_count=0
  - data_out=0; stored contents are don't-care
- Load-to-stream latency: data_out_valid rises the cycle after the final load beat is accepted.
- Streaming throughput: one beat per cycle while data_out_ready=1; no bubbles at wrap-around or pass boundaries.
- Handshake: once data_out_valid=1, data_out and valid hold stable until accepted. data_out_valid does not depend combinationally on data_out_ready.
- Frame end: after the final accepted beat, data_out_valid=0 and done=1 on the next cycle.
- start in DONE: data_out_valid=1 and done=0 on the next cycle.
- reload in DONE: load_ready=1 on the next cycle.
- DEPTH=1: every accepted beat wraps and increments pass.
- Reset mid-operation: an asynchronous return to reset values; no partial beat is emitted afterwards.

## Test plan
- Basic replay, DEPTH=4, REPEAT=3: load beats {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,0} back-to-back.
  - Expect 12 output beats in load order.
  - Expect pass_count 0→1→2→3, then done=1 one cycle after the 12th accept.
- Backpressure: data_out_ready toggles in a 1-0-0-1 pattern.
  - data_out stays stable across stalls; no beat is duplicated or skipped; total stays 12.
- Restart: assert start in DONE.
  - Next cycle shows data_out_valid=1 with beat {1,2,3,4} and pass_count=0.
- Reload priority: assert start and reload in the same cycle in DONE.
  - Block enters LOAD with load_ready=1.
  - A new tensor {7,7,7,7}×4 is then replayed exclusively.
- Ignored requests and load gaps:
  - Pulse start and reload mid-STREAM: stream continues unaffected.
  - load_valid gaps during LOAD: wr_ptr advances only on accepted beats.
- Reset mid-stream: drive rst=0 during pass 1.
  - Outputs take reset values immediately: data_out_valid=0, load_ready=1, pass_count=0.
- DEPTH=1, REPEAT=2: load one beat, then expect exactly 2 identical output beats.
